paddle_ctl: RTL and testbench

Per-frame position controller for the two PONG paddles. It samples both players' up/down buttons and advances each paddle once per video frame, at the vsync rising edge, so positions never change mid-frame. Movement accelerates while a button is held and is clamped to the visible field. Its outputs `y_pos` and `y_pos_sec` drive the paddle-drawing stage directly.

---
 rtl/pong_pkg.sv | 33 +++
 rtl/paddle_step.sv | 96 +++++++++
 rtl/paddle_ctl.sv | 152 +++++++++++++++
 tb/tb_paddle_ctl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared PONG constants (screen/paddle geometry, derived paddle
//               limits) and the encodings used by the paddle controller.
// Contents    : PONG_SCREEN_H, PONG_PADDLE_LEN, PONG_Y_MAX, PONG_Y_START,
//               state_t (controller FSM), dir_t (per-player direction).
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

   localparam int PONG_SCREEN_H   = 600;
   localparam int PONG_PADDLE_LEN = 80;

   // Largest legal top-edge row keeps the whole paddle on screen.
   localparam int PONG_Y_MAX   = PONG_SCREEN_H - PONG_PADDLE_LEN;
   localparam int PONG_Y_START = PONG_Y_MAX / 2;

   typedef enum logic [1:0] {
      S_CENTER = 2'd0,
      S_IDLE   = 2'd1,
      S_UPD_L  = 2'd2,
      S_UPD_R  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_t;

endpackage
`default_nettype wire

// File: rtl/paddle_step.sv
`default_nettype none
// ============================================================================
// Module      : paddle_step
// Description : One player's motion state (hold counter, last moving
//               direction) and the combinational next clamped position.
// Ports       : pclk   - clock
//               rst    - synchronous reset, active-low
//               clr    - clear the hold counter (recenter)
//               en     - commit this frame's step
//               up/dn  - snapshotted buttons for this frame
//               y_cur  - current top-edge row
//               y_next - next top-edge row (valid while up/dn/y_cur stable)
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_step
   import pong_pkg::*;
#(
   parameter int Y_MAX        = PONG_Y_MAX,
   parameter int SPEED_MIN    = 2,
   parameter int SPEED_MAX    = 8,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        up,
   input  logic        dn,
   input  logic [11:0] y_cur,
   output logic [11:0] y_next
);

   localparam int HOLD_MAX = ACCEL_FRAMES * (SPEED_MAX - SPEED_MIN);
   localparam int HOLD_W   = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(HOLD_MAX);

   dir_t               dir;
   dir_t               last_dir;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [HOLD_W-1:0]  hold_nxt;
   logic signed [12:0] speed;
   logic signed [12:0] y_s;
   logic signed [12:0] y_sum;

   always_comb begin
      dir = DIR_NONE;
      if (up && !dn)
         dir = DIR_UP;
      else if (dn && !up)
         dir = DIR_DN;

      // Only an uninterrupted hold in the same direction keeps accelerating.
      hold_nxt = '0;
      if (dir != DIR_NONE && dir == last_dir)
         hold_nxt = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HOLD_W'(1);

      // Speed uses this frame's updated hold count.
      speed = 13'(SPEED_MIN) + 13'(hold_nxt) / 13'(ACCEL_FRAMES);
      if (speed > 13'(SPEED_MAX))
         speed = 13'(SPEED_MAX);

      // Signed 13-bit math so an upward step below row 0 is caught, not wrapped.
      y_s   = $signed({1'b0, y_cur});
      y_sum = y_s;
      case (dir)
         DIR_UP: begin
            y_sum = y_s - speed;
            if (y_sum < 0)
               y_sum = '0;
         end
         DIR_DN: begin
            y_sum = y_s + speed;
            if (y_sum > 13'(Y_MAX))
               y_sum = 13'(Y_MAX);
         end
         default: ;
      endcase
      y_next = y_sum[11:0];
   end

   always_ff @(posedge pclk) begin
      if (!rst) begin
         hold_cnt <= '0;
         last_dir <= DIR_NONE;
      end else if (clr) begin
         hold_cnt <= '0;
      end else if (en) begin
         hold_cnt <= hold_nxt;
         // Remember only directions that actually moved the paddle.
         if (dir != DIR_NONE)
            last_dir <= dir;
      end
   end

endmodule
`default_nettype wire

// File: rtl/paddle_ctl.sv
`default_nettype none
// ============================================================================
// Module      : paddle_ctl
// Description : Per-frame position controller for both PONG paddles. Buttons
//               are synchronized, snapshotted on the vsync rising edge and
//               applied to the left then the right paddle.
// Ports       : pclk      - pixel clock
//               rst       - synchronous reset, active-low
//               vsync_in  - vsync, pclk domain
//               btn_up_l/btn_dn_l, btn_up_r/btn_dn_r - async buttons
//               game_en   - 0 freezes paddles
//               recenter  - pulse, return both paddles to Y_START
//               y_pos     - left paddle top row
//               y_pos_sec - right paddle top row
//               upd_done  - one-cycle pulse after both paddles update
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_ctl
   import pong_pkg::*;
#(
   parameter int Y_MAX        = PONG_Y_MAX,
   parameter int Y_START      = PONG_Y_START,
   parameter int SPEED_MIN    = 2,
   parameter int SPEED_MAX    = 8,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vsync_in,
   input  logic        btn_up_l,
   input  logic        btn_dn_l,
   input  logic        btn_up_r,
   input  logic        btn_dn_r,
   input  logic        game_en,
   input  logic        recenter,
   output logic [11:0] y_pos,
   output logic [11:0] y_pos_sec,
   output logic        upd_done
);

   localparam logic [11:0] Y_START_V = 12'(Y_START);

   // Bit order everywhere: {up_l, dn_l, up_r, dn_r}
   logic [3:0]  btn_meta;
   logic [3:0]  btn_sync;
   logic [3:0]  snap;
   logic        vs_r;
   logic        vs_prev;
   logic        tick;
   logic        rc_pend;
   state_t      state;
   logic [11:0] y_next_l;
   logic [11:0] y_next_r;
   logic        center_cyc;
   logic        en_l;
   logic        en_r;

   always_ff @(posedge pclk) begin
      if (!rst) begin
         btn_meta <= '0;
         btn_sync <= '0;
         vs_r     <= 1'b0;
         vs_prev  <= 1'b0;
      end else begin
         btn_meta <= {btn_up_l, btn_dn_l, btn_up_r, btn_dn_r};
         btn_sync <= btn_meta;
         vs_r     <= vsync_in;
         vs_prev  <= vs_r;
      end
   end

   assign tick       = vs_r & ~vs_prev;
   assign center_cyc = (state == S_CENTER);
   assign en_l       = (state == S_UPD_L);
   assign en_r       = (state == S_UPD_R);

   always_ff @(posedge pclk) begin
      if (!rst) begin
         state     <= S_CENTER;
         snap      <= '0;
         rc_pend   <= 1'b0;
         y_pos     <= Y_START_V;
         y_pos_sec <= Y_START_V;
         upd_done  <= 1'b0;
      end else begin
         upd_done <= 1'b0;
         case (state)
            S_CENTER: begin
               y_pos     <= Y_START_V;
               y_pos_sec <= Y_START_V;
               rc_pend   <= 1'b0;
               state     <= S_IDLE;
            end
            S_IDLE: begin
               // Recenter wins over a coincident tick; that frame is skipped.
               if (recenter || rc_pend) begin
                  state <= S_CENTER;
               end else if (tick && game_en) begin
                  snap  <= btn_sync;
                  state <= S_UPD_L;
               end
            end
            S_UPD_L: begin
               y_pos   <= y_next_l;
               rc_pend <= rc_pend | recenter;
               state   <= S_UPD_R;
            end
            S_UPD_R: begin
               y_pos_sec <= y_next_r;
               upd_done  <= 1'b1;
               rc_pend   <= rc_pend | recenter;
               state     <= (recenter || rc_pend) ? S_CENTER : S_IDLE;
            end
            default: state <= S_CENTER;
         endcase
      end
   end

   paddle_step #(
      .Y_MAX       (Y_MAX),
      .SPEED_MIN   (SPEED_MIN),
      .SPEED_MAX   (SPEED_MAX),
      .ACCEL_FRAMES(ACCEL_FRAMES)
   ) u_step_l (
      .pclk  (pclk),
      .rst   (rst),
      .clr   (center_cyc),
      .en    (en_l),
      .up    (snap[3]),
      .dn    (snap[2]),
      .y_cur (y_pos),
      .y_next(y_next_l)
   );

   paddle_step #(
      .Y_MAX       (Y_MAX),
      .SPEED_MIN   (SPEED_MIN),
      .SPEED_MAX   (SPEED_MAX),
      .ACCEL_FRAMES(ACCEL_FRAMES)
   ) u_step_r (
      .pclk  (pclk),
      .rst   (rst),
      .clr   (center_cyc),
      .en    (en_r),
      .up    (snap[1]),
      .dn    (snap[0]),
      .y_cur (y_pos_sec),
      .y_next(y_next_r)
   );

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_paddle_ctl
// Description : Self-checking bench for paddle_ctl: fixed frame table,
//               hand sequences for multi-cycle corners, randomized frames
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_ctl;

   localparam int Y_MAX_T    = 520;
   localparam int Y_START_T  = 260;
   localparam int SPD_MIN_T  = 2;
   localparam int SPD_MAX_T  = 8;
   localparam int ACCEL_T    = 8;
   localparam int HOLD_LIM_T = ACCEL_T * (SPD_MAX_T - SPD_MIN_T);

   logic        pclk;
   logic        rst;
   logic        vsync_in;
   logic        btn_up_l, btn_dn_l, btn_up_r, btn_dn_r;
   logic        game_en;
   logic        recenter;
   logic [11:0] y_pos;
   logic [11:0] y_pos_sec;
   logic        upd_done;

   int n_vec = 0;
   int n_err = 0;

   // Frame-level model state: index 0 = left, 1 = right
   int m_y[2];
   int m_hold[2];
   int m_last[2];

   typedef struct {
      bit ul, dl, ur, dr, en;
      int rc;          // 0 none, 1 with tick, 2 during left update
      int exp_l, exp_r;
   } vec_t;

   vec_t tbl[27];

   paddle_ctl dut (
      .pclk     (pclk),
      .rst      (rst),
      .vsync_in (vsync_in),
      .btn_up_l (btn_up_l),
      .btn_dn_l (btn_dn_l),
      .btn_up_r (btn_up_r),
      .btn_dn_r (btn_dn_r),
      .game_en  (game_en),
      .recenter (recenter),
      .y_pos    (y_pos),
      .y_pos_sec(y_pos_sec),
      .upd_done (upd_done)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void m_reset();
      for (int p = 0; p < 2; p++) begin
         m_y[p] = Y_START_T; m_hold[p] = 0; m_last[p] = 0;
      end
   endfunction

   function automatic void m_center();
      for (int p = 0; p < 2; p++) begin
         m_y[p] = Y_START_T; m_hold[p] = 0;
      end
   endfunction

   function automatic void m_step(input int p, input bit up, input bit dn);
      int d;
      int spd;
      d = (up && !dn) ? -1 : ((dn && !up) ? 1 : 0);
      if (d == 0 || d != m_last[p]) m_hold[p] = 0;
      else if (m_hold[p] < HOLD_LIM_T) m_hold[p] = m_hold[p] + 1;
      if (d != 0) m_last[p] = d;
      spd = SPD_MIN_T + m_hold[p] / ACCEL_T;
      if (spd > SPD_MAX_T) spd = SPD_MAX_T;
      m_y[p] = m_y[p] + d * spd;
      if (m_y[p] < 0) m_y[p] = 0;
      if (m_y[p] > Y_MAX_T) m_y[p] = Y_MAX_T;
   endfunction

   // One video frame: settle buttons, raise vsync, watch upd_done for 8 edges.
   task automatic run_frame(input bit ul, input bit dl, input bit ur, input bit dr,
                            input bit en, input int rc,
                            output int done_k, output int pulses);
      btn_up_l = ul; btn_dn_l = dl; btn_up_r = ur; btn_dn_r = dr;
      game_en = en;
      repeat (4) @(posedge pclk);
      #1 vsync_in = 1'b1;
      done_k = 0;
      pulses = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge pclk);
         #1;
         if (upd_done) begin
            pulses++;
            if (done_k == 0) done_k = k;
         end
         recenter = ((k == 1 && rc == 1) || (k == 2 && rc == 2));
      end
      vsync_in = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      if (rc == 1) begin
         m_center();
      end else begin
         if (en) begin
            m_step(0, ul, dl);
            m_step(1, ur, dr);
         end
         if (rc == 2) m_center();
      end
   endtask

   task automatic check_model(input string tag, input int done_k, input int pulses,
                              input bit exp_done);
      check({tag, " y_pos"}, int'(y_pos), m_y[0]);
      check({tag, " y_pos_sec"}, int'(y_pos_sec), m_y[1]);
      check({tag, " done_pulses"}, pulses, exp_done ? 1 : 0);
      check({tag, " done_latency"}, done_k, exp_done ? 4 : 0);
   endtask

   initial begin
      int dk, np;
      bit ul, dl, ur, dr, en;
      int rc, r;

      // ul dl ur dr en rc  exp_l exp_r
      tbl[0]  = '{0,0,0,0,1,0, 260,260};
      tbl[1]  = '{0,0,0,0,1,0, 260,260};
      tbl[2]  = '{0,0,0,0,1,0, 260,260};
      tbl[3]  = '{0,1,0,0,1,0, 262,260};
      tbl[4]  = '{0,1,0,0,1,0, 264,260};
      tbl[5]  = '{0,1,0,0,1,0, 266,260};
      tbl[6]  = '{0,1,0,0,1,0, 268,260};
      tbl[7]  = '{0,1,0,0,1,0, 270,260};
      tbl[8]  = '{0,1,0,0,1,0, 272,260};
      tbl[9]  = '{0,1,0,0,1,0, 274,260};
      tbl[10] = '{0,1,0,0,1,0, 276,260};
      tbl[11] = '{0,1,0,0,1,0, 279,260};
      tbl[12] = '{0,1,0,0,1,0, 282,260};
      tbl[13] = '{1,1,0,0,1,0, 282,260};
      tbl[14] = '{0,1,0,0,1,0, 284,260};
      tbl[15] = '{1,0,0,0,1,0, 282,260};
      tbl[16] = '{1,0,0,0,1,0, 280,260};
      tbl[17] = '{0,1,0,0,1,0, 282,260};
      tbl[18] = '{0,1,0,0,0,0, 282,260};
      tbl[19] = '{0,1,0,0,1,0, 284,260};
      tbl[20] = '{0,1,0,0,1,1, 260,260};
      tbl[21] = '{0,1,0,0,1,0, 262,260};
      tbl[22] = '{0,0,1,0,1,0, 262,258};
      tbl[23] = '{0,0,0,1,1,0, 262,260};
      tbl[24] = '{0,0,1,1,1,0, 262,260};
      tbl[25] = '{0,0,0,0,1,0, 262,260};
      tbl[26] = '{1,0,0,1,1,0, 260,262};

      rst = 1'b0; vsync_in = 1'b0; recenter = 1'b0; game_en = 1'b0;
      btn_up_l = 1'b0; btn_dn_l = 1'b0; btn_up_r = 1'b0; btn_dn_r = 1'b0;
      m_reset();
      repeat (3) @(posedge pclk);
      #1;
      check("reset y_pos", int'(y_pos), Y_START_T);
      check("reset y_pos_sec", int'(y_pos_sec), Y_START_T);
      check("reset upd_done", int'(upd_done), 0);
      rst = 1'b1;
      repeat (3) @(posedge pclk);
      #1;

      for (int i = 0; i < 27; i++) begin
         run_frame(tbl[i].ul, tbl[i].dl, tbl[i].ur, tbl[i].dr, tbl[i].en, tbl[i].rc, dk, np);
         check($sformatf("tbl%0d y_pos", i), int'(y_pos), tbl[i].exp_l);
         check($sformatf("tbl%0d y_pos_sec", i), int'(y_pos_sec), tbl[i].exp_r);
         check($sformatf("tbl%0d done_pulses", i), np,
               (tbl[i].en && tbl[i].rc != 1) ? 1 : 0);
         check($sformatf("tbl%0d done_latency", i), dk,
               (tbl[i].en && tbl[i].rc != 1) ? 4 : 0);
      end

      // Recenter while the left paddle is updating: frame completes, then center.
      run_frame(0, 1, 0, 1, 1, 2, dk, np);
      check_model("rc_mid_update", dk, np, 1'b1);
      check("rc_mid_update y_pos centered", int'(y_pos), Y_START_T);

      // Freeze for 5 frames with a button held.
      for (int i = 0; i < 5; i++) begin
         run_frame(0, 0, 1, 0, 0, 0, dk, np);
         check_model("freeze", dk, np, 1'b0);
      end

      // Clamp at top, then at bottom, on the right paddle.
      for (int i = 0; i < 200; i++) begin
         run_frame(0, 0, 1, 0, 1, 0, dk, np);
         check_model("clamp_top", dk, np, 1'b1);
      end
      check("clamp_top final", int'(y_pos_sec), 0);
      for (int i = 0; i < 200; i++) begin
         run_frame(0, 0, 0, 1, 1, 0, dk, np);
         check_model("clamp_bot", dk, np, 1'b1);
      end
      check("clamp_bot final", int'(y_pos_sec), Y_MAX_T);

      // Reset asserted while the left update is in flight.
      btn_up_l = 1'b0; btn_dn_l = 1'b1; btn_up_r = 1'b0; btn_dn_r = 1'b0; game_en = 1'b1;
      repeat (4) @(posedge pclk);
      #1 vsync_in = 1'b1;
      @(posedge pclk);
      #1;
      @(posedge pclk);
      #1 rst = 1'b0;
      @(posedge pclk);
      #1;
      check("rst_mid y_pos", int'(y_pos), Y_START_T);
      check("rst_mid y_pos_sec", int'(y_pos_sec), Y_START_T);
      check("rst_mid upd_done", int'(upd_done), 0);
      vsync_in = 1'b0;
      np = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge pclk);
         #1;
         if (upd_done) np++;
      end
      check("rst_mid no done", np, 0);
      rst = 1'b1;
      m_reset();
      repeat (3) @(posedge pclk);
      #1;
      run_frame(0, 1, 0, 0, 1, 0, dk, np);
      check_model("after_rst", dk, np, 1'b1);

      // Randomized frames with sticky buttons so acceleration gets exercised.
      ul = 0; dl = 0; ur = 0; dr = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            ul = 1'($urandom_range(0, 1)); dl = 1'($urandom_range(0, 1));
            ur = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
         end
         en = ($urandom_range(0, 9) != 0);
         r  = int'($urandom_range(0, 24));
         rc = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
         run_frame(ul, dl, ur, dr, en, rc, dk, np);
         check_model($sformatf("rand%0d", i), dk, np, en && (rc != 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
